// File: rtl/dds_param_scheduler.sv
// Timed parameter scheduler: queues timestamped freq/phase/offset updates and applies each to the
// phase MAC when the global timestamp reaches its trigger time. Build option: DDS_SCHED_LATE_DROP_EN.
module dds_param_scheduler #(
   parameter int DEPTH = 16,
   parameter int LW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [47:0]   timestamp,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [47:0]   cmd_time,
   input  logic [47:0]   cmd_freq,
   input  logic [13:0]   cmd_phase,
   input  logic [47:0]   cmd_offset,
   input  logic          flush,
   output logic [47:0]   freq_out,
   output logic [13:0]   phase_out,
   output logic [47:0]   offset_out,
   output logic          update,
   output logic          late,
   output logic [LW:0]   level,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic [47:0] t;
      logic [47:0] freq;
      logic [13:0] phase;
      logic [47:0] offset;
   } entry_t;

   localparam logic [LW:0] FULL = (LW+1)'(DEPTH);

   state_t        state;
   state_t        state_nxt;
   entry_t        mem [DEPTH];
   entry_t        head;
   logic [LW-1:0] wr_ptr;
   logic [LW-1:0] rd_ptr;
   logic          rdy_en;
   logic          push;
   logic          pop;
   logic          apply;
   logic          set_late;
   logic          due;
   logic          overdue;

   // Handshake: a command transfers on any clk edge where cmd_valid && cmd_ready are both high.
   // cmd_ready never looks at cmd_valid, and a same-cycle pop cannot raise it when full.
   assign cmd_ready = rdy_en && (level != FULL) && !flush;
   assign push      = cmd_valid && cmd_ready;
   assign due       = (timestamp >= head.t);
   assign overdue   = (timestamp > head.t);
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      apply     = 1'b0;
      set_late  = 1'b0;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (level != '0) begin
                  pop       = 1'b1;
                  state_nxt = S_LOAD;
               end
            end
            S_LOAD: begin
               state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (due) begin
                  set_late = overdue;
`ifdef DDS_SCHED_LATE_DROP_EN
                  apply    = !overdue;
`else
                  apply    = 1'b1;
`endif
                  if (level != '0) begin
                     pop       = 1'b1;
                     state_nxt = S_LOAD;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         rdy_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
      end
   end

   // Storage array carries no reset; occupancy is tracked entirely by the pointers and level.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{t: cmd_time, freq: cmd_freq, phase: cmd_phase, offset: cmd_offset};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head <= '0;
      end else if (flush) begin
         head <= '0;
      end else if (pop) begin
         head <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         freq_out   <= '0;
         phase_out  <= '0;
         offset_out <= '0;
         update     <= 1'b0;
         late       <= 1'b0;
      end else begin
         update <= apply;
         if (apply) begin
            freq_out   <= head.freq;
            phase_out  <= head.phase;
            offset_out <= head.offset;
         end
         if (flush) begin
            late <= 1'b0;
         end else if (set_late) begin
            late <= 1'b1;
         end
      end
   end

endmodule
